uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 10416, is the clock cycles per UART bit (100 MHz / 9600 baud); legal range >= 2.
REQ-002 Parameter DATA_W, default 8, is the payload bits per frame.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 empty  input  1  upstream FIFO empty flag.
REQ-006 pop_data  input  DATA_W  upstream FIFO head word, valid combinationally whenever empty=0 (first-word-fall-through).
REQ-007 pop  output  1  one-cycle read strobe to the upstream FIFO.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 tx_busy  output  1  high while a frame is in progress.
REQ-010 tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-011 Frame format: 8N1 -- start bit 0, DATA_W data bits LSB first, one stop bit 1.
REQ-012 FSM states: IDLE, START, DATA, STOP.
REQ-013 IDLE with empty=0: pop=1 combinationally for that cycle; on the same edge pop_data is latched into the shift register, the state goes to START, and the bit counter and baud counter are cleared.
REQ-014 IDLE with empty=1: pop=0, tx=1, no state change.
REQ-015 pop is 0 in every state other than IDLE and whenever rst=1.
REQ-016 The baud counter runs 0..BAUD_DIV-1 only outside IDLE; a bit-end tick occurs when it equals BAUD_DIV-1, then it wraps to 0.
REQ-017 START: tx=0 for exactly BAUD_DIV cycles, then go to DATA.
REQ-018 DATA: tx equals shift register bit 0; on each tick, shift right and increment the bit counter; after the DATA_W-th tick, go to STOP.
REQ-019 STOP: tx=1 for BAUD_DIV cycles; on the tick, tx_done=1 for that single cycle and the state goes to IDLE.
REQ-020 tx is registered: the first start-bit cycle is the cycle after the pop edge; frame length is exactly (DATA_W+2)*BAUD_DIV cycles.
REQ-021 Back-to-back bytes: exactly one IDLE cycle (tx=1) separates consecutive frames, so the pop period is (DATA_W+2)*BAUD_DIV+1 cycles.
REQ-022 Changes on empty or pop_data outside IDLE are ignored; the frame in flight is not disturbed.
REQ-023 tx_busy = (state != IDLE).
REQ-024 Counter widths: baud counter $clog2(BAUD_DIV) bits; bit counter $clog2(DATA_W+1) bits; no overflow at maximum counts.

Reset
REQ-025 While rst=1, at the next edge: state=IDLE, tx=1, tx_busy=0, tx_done=0, pop=0, all counters and the shift register are cleared.
REQ-026 Reset mid-frame aborts the frame; the latched byte is discarded and not re-popped.
REQ-027 A new frame may start on the first cycle after rst deasserts.

Structure
REQ-028 The shared package uart_pkg holds the FSM state encoding (2-bit localparams), the default DATA_W, and the default BAUD_DIV.
REQ-029 The baud counter is one sub-module, uart_baud_cnt, with ports clk, rst, en, and tick; the FSM and shift register stay in uart_tx_fifo.

Verification (BAUD_DIV=4, DATA_W=8)
REQ-030 Reset: rst=1 for 2 cycles -> tx=1, pop=0, tx_busy=0, tx_done=0.
REQ-031 Single byte: empty=0 with pop_data=8'h61, empty=1 after pop -> pop high for exactly 1 cycle; tx holds 0,1,0,0,0,0,1,1,0,1 for 4 cycles each; tx_done pulses on cycle 40 after pop.
REQ-032 Burst: FIFO model holds 8'h61, 8'h62, 8'h63 -> 3 pops spaced 41 cycles apart; bytes decoded from tx match in order; no 4th pop.
REQ-033 Idle: empty=1 for 100 cycles -> pop=0, tx=1, tx_busy=0 throughout.
REQ-034 Abort: rst=1 for 1 cycle during data bit 3 of 8'hA5 -> next cycle tx=1 and tx_busy=0; after release with empty=0 and pop_data=8'h3C, a clean frame of 8'h3C follows.
REQ-035 Interference: toggle empty and pop_data randomly during a frame of 8'h55 -> tx waveform unchanged; pop stays 0 until the next IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default frame geometry and the line-level helper used by the transmitter.
package uart_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_BAUD_DIV = 10416;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_START_ENC = 2'd1;
    localparam logic [1:0] ST_DATA_ENC  = 2'd2;
    localparam logic [1:0] ST_STOP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_START = ST_START_ENC,
        ST_DATA  = ST_DATA_ENC,
        ST_STOP  = ST_STOP_ENC
    } tx_state_t;

    // Serial line level driven while the FSM sits in the given state.
    function automatic logic line_level(input tx_state_t st, input logic data_bit);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the
// final cycle of each bit; held at zero while disabled.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Baud counter register with wrap at the bit-end cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a first-word-fall-through FIFO: pops one
// word whenever idle and the FIFO is non-empty, then serialises it LSB first.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int DATA_W   = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [DATA_W-1:0] pop_data,
    output logic              pop,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state_r;
    tx_state_t         state_nxt_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nxt_s;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [BIT_W-1:0]  bit_cnt_nxt_s;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              baud_en_s;
    logic              tick_s;
    logic              pop_s;
    logic              done_s;

    assign baud_en_s = (state_r != ST_IDLE);

    uart_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_cnt (
        .clk (clk),
        .rst (rst),
        .en  (baud_en_s),
        .tick(tick_s)
    );

    // Next-state, shift register and strobe decode.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        pop_s         = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty) begin
                    pop_s         = 1'b1;
                    shift_nxt_s   = pop_data;
                    bit_cnt_nxt_s = '0;
                    state_nxt_s   = ST_START;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_nxt_s   = shift_r >> 1'b1;
                    bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // tx is registered, so it follows the state being entered, not the current one.
        tx_nxt_s = line_level(state_nxt_s, shift_nxt_s[0]);
    end

    // FSM, shift register, bit counter and serial line registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            tx_r      <= tx_nxt_s;
        end
    end

    assign pop     = pop_s & ~rst;
    assign tx      = tx_r;
    assign tx_busy = (state_r != ST_IDLE);
    assign tx_done = done_s;

endmodule
